// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with register file write-back
// Optional FAST_MUL_EN: single-step 64-bit multiply, MUL state skipped.
module muldiv_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            funct3,
  input  logic [DATA_W-1:0]     rs1_data,
  input  logic [DATA_W-1:0]     rs2_data,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  flush,
  output logic                  busy,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_write_reg,
  output logic [DATA_W-1:0]     wb_write_data
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [DATA_W-1:0] MIN_INT = {1'b1, {(DATA_W-1){1'b0}}};

  state_t                  r_state;
  state_t                  w_state_next;
  logic [5:0]              r_cnt;
  logic [1:0]              r_op;
  logic [REG_ADDR_W-1:0]   r_rd;
  logic [DATA_W-1:0]       r_hi;
  logic [DATA_W-1:0]       r_lo;
  logic [DATA_W-1:0]       r_b;
  logic                    r_neg_q;
  logic                    r_neg_r;
  logic [REG_ADDR_W-1:0]   r_wb_reg;
  logic [DATA_W-1:0]       r_wb_data;

  logic                    w_accept;
  logic                    w_s1;
  logic                    w_s2;
  logic                    w_neg1;
  logic                    w_neg2;
  logic [DATA_W-1:0]       w_mag1;
  logic [DATA_W-1:0]       w_mag2;
  logic                    w_div0;
  logic                    w_ovf;
  logic                    w_special;
  logic [DATA_W-1:0]       w_special_data;
  logic                    w_last_step;

  assign in_ready     = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign wb_reg_write = (r_state == S_DONE) && (r_rd != '0) && !flush;
  assign wb_write_reg  = r_wb_reg;
  assign wb_write_data = r_wb_data;

  assign w_accept = in_valid && (r_state == S_IDLE) && !flush;

  // Operand signedness: MULHSU signs only rs1, the U variants sign nothing.
  assign w_s1   = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign w_s2   = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign w_neg1 = w_s1 & rs1_data[DATA_W-1];
  assign w_neg2 = w_s2 & rs2_data[DATA_W-1];
  assign w_mag1 = w_neg1 ? (~rs1_data + 1'b1) : rs1_data;
  assign w_mag2 = w_neg2 ? (~rs2_data + 1'b1) : rs2_data;

  assign w_div0    = funct3[2] && (rs2_data == '0);
  assign w_ovf     = funct3[2] && !funct3[0] && (rs1_data == MIN_INT) && (rs2_data == '1);
  assign w_special = w_div0 || w_ovf;

  always_comb begin
    w_special_data = '0;
    if (w_div0)
      w_special_data = funct3[1] ? rs1_data : '1;
    else if (w_ovf)
      w_special_data = funct3[1] ? '0 : MIN_INT;
  end

`ifdef FAST_MUL_EN
  logic [2*DATA_W-1:0] w_fa;
  logic [2*DATA_W-1:0] w_fb;
  logic [2*DATA_W-1:0] w_fast_prod;
  logic [DATA_W-1:0]   w_fast_res;
  assign w_fa        = {{DATA_W{w_neg1}}, rs1_data};
  assign w_fb        = {{DATA_W{w_neg2}}, rs2_data};
  assign w_fast_prod = w_fa * w_fb;
  assign w_fast_res  = (funct3[1:0] == 2'b00) ? w_fast_prod[DATA_W-1:0]
                                              : w_fast_prod[2*DATA_W-1:DATA_W];
`endif

  // Shift-add step: r_hi accumulates, r_lo holds the multiplier and fills with product bits.
  logic [DATA_W:0]     w_add;
  logic [DATA_W-1:0]   w_mul_hi;
  logic [DATA_W-1:0]   w_mul_lo;
  assign w_add    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_mul_hi = w_add[DATA_W:1];
  assign w_mul_lo = {w_add[0], r_lo[DATA_W-1:1]};

  // Restoring division step: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  logic [DATA_W:0]     w_rsh;
  logic [DATA_W:0]     w_rsub;
  logic                w_ge;
  logic [DATA_W-1:0]   w_div_hi;
  logic [DATA_W-1:0]   w_div_lo;
  assign w_rsh    = {r_hi, r_lo[DATA_W-1]};
  assign w_rsub   = w_rsh - {1'b0, r_b};
  assign w_ge     = (w_rsh >= {1'b0, r_b});
  assign w_div_hi = w_ge ? w_rsub[DATA_W-1:0] : w_rsh[DATA_W-1:0];
  assign w_div_lo = {r_lo[DATA_W-2:0], w_ge};

  logic [2*DATA_W-1:0] w_prod;
  logic [2*DATA_W-1:0] w_prod_s;
  logic [DATA_W-1:0]   w_mul_res;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_div_res;
  assign w_prod    = {w_mul_hi, w_mul_lo};
  assign w_prod_s  = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_mul_res = (r_op == 2'b00) ? w_prod_s[DATA_W-1:0] : w_prod_s[2*DATA_W-1:DATA_W];
  assign w_quot    = r_neg_q ? (~w_div_lo + 1'b1) : w_div_lo;
  assign w_rem     = r_neg_r ? (~w_div_hi + 1'b1) : w_div_hi;
  assign w_div_res = r_op[1] ? w_rem : w_quot;

  assign w_last_step = (r_cnt == 6'd31);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_special)
            w_state_next = S_DONE;
          else if (funct3[2])
            w_state_next = S_DIV;
          else
`ifdef FAST_MUL_EN
            w_state_next = S_DONE;
`else
            w_state_next = S_MUL;
`endif
        end
      end
      S_MUL, S_DIV: begin
        if (flush)
          w_state_next = S_IDLE;
        else if (w_last_step)
          w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_rd      <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_wb_reg  <= '0;
      r_wb_data <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_op    <= funct3[1:0];
      r_rd    <= rd;
      r_hi    <= '0;
      r_lo    <= w_mag1;
      r_b     <= w_mag2;
      r_neg_q <= w_neg1 ^ w_neg2;
      r_neg_r <= w_neg1;
      if (w_special) begin
        r_wb_reg  <= rd;
        r_wb_data <= w_special_data;
      end
`ifdef FAST_MUL_EN
      else if (!funct3[2]) begin
        r_wb_reg  <= rd;
        r_wb_data <= w_fast_res;
      end
`endif
    end else if ((r_state == S_MUL || r_state == S_DIV) && !flush) begin
      r_cnt <= r_cnt + 6'd1;
      if (r_state == S_MUL) begin
        r_hi <= w_mul_hi;
        r_lo <= w_mul_lo;
      end else begin
        r_hi <= w_div_hi;
        r_lo <= w_div_lo;
      end
      if (w_last_step) begin
        r_wb_reg  <= r_rd;
        r_wb_data <= (r_state == S_MUL) ? w_mul_res : w_div_res;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle RV32M execute unit, directly downstream of the register file read ports; it consumes read_data_one/read_data_two as rs1/rs2 operands.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively.
- Drives the register file write port (write_reg/write_data/reg_write) with a one-cycle write-back pulse.
- Protects x0, since the register file does not.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- REG_ADDR_W, 5, destination register index width.

Ports:
- sysclk  in  1  system clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit idle, request accepted this edge if in_valid.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  in  DATA_W  operand A, from read_data_one.
- rs2_data  in  DATA_W  operand B, from read_data_two.
- rd  in  REG_ADDR_W  destination register.
- flush  in  1  abort the in-flight operation, no write-back.
- busy  out  1  operation in flight (state != IDLE).
- wb_reg_write  out  1  to reg_write.
- wb_write_reg  out  REG_ADDR_W  to write_reg.
- wb_write_data  out  DATA_W  to write_data.

Behaviour:
- Reset values:
  - state=IDLE, in_ready=1, busy=0.
  - wb_reg_write=0, wb_write_reg=0, wb_write_data=0.
  - Counter and datapath registers=0.
- Reset asserted mid-operation: immediate return to IDLE, no write-back is ever produced for the aborted op.
- Acceptance: in_valid && in_ready at a posedge (E0) latches funct3, rd and operands.
  - Later changes on the inputs are ignored until the next acceptance.
- States:
  - IDLE: in_ready=1. Accept goes to MUL (funct3[2]=0) or DIV (funct3[2]=1), except the special cases below, which go to DONE.
  - MUL: 32 shift-add steps on |A|,|B| (magnitudes per signedness), one per edge E1..E32, 6-bit counter. At E32 go to DONE.
  - DIV: 32 restoring-division steps on magnitudes, one per edge E1..E32. At E32 go to DONE.
  - DONE: result is sign-corrected and registered on entry. wb_reg_write=1 for exactly this one cycle. Next edge goes to IDLE.
- Latency:
  - Normal op: wb_reg_write high in the cycle after E32, i.e. 33 cycles after the acceptance edge.
  - Next acceptance is possible at the edge ending DONE+1 (IDLE).
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Sign rules:
  - Product sign = XOR of operand signs (signed operands only).
  - Quotient sign = XOR of operand signs.
  - Remainder sign = dividend sign.
- Result selection:
  - MUL: low 32 bits of the 64-bit product.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Special cases, detected at acceptance, go straight to DONE (wb 1 cycle after E0):
  - Divide by zero (rs2=0): DIV/DIVU result 0xFFFFFFFF, REM/REMU result rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV result 0x80000000, REM result 0.
- x0 protection: if the latched rd==0, wb_reg_write stays 0 in DONE. Timing and state sequence are unchanged.
- flush:
  - Flush in MUL/DIV/DONE: next edge goes to IDLE, and wb_reg_write is forced 0 in that cycle if in DONE.
  - Flush and in_valid together in IDLE: flush wins, nothing is accepted.
- Output timing: wb_write_reg and wb_write_data hold their last values outside DONE. Only wb_reg_write qualifies them.

Optional Feature:
- FAST_MUL_EN defined:
  - MUL-class ops compute a full 64-bit product in one step using the synthesis multiplier and skip the MUL state.
  - Acceptance goes to DONE, so wb is 1 cycle after E0.
  - DIV timing is unchanged.
- Not defined: the iterative 32-step MUL path as above.

Test Plan:
- Reset: rst=1 mid-DIV at cycle 10 -> state IDLE, in_ready=1, wb_reg_write never pulses; all outputs 0.
- MUL with rd=5, rs1=0xFFFFFFFE (-2), rs2=3 -> wb_reg_write=1 exactly 33 cycles after acceptance, write_reg=5, data=0xFFFFFFFA. MULH same operands -> 0xFFFFFFFF. MULHU -> 0x00000002.
- DIV rd=7, rs1=-7 (0xFFFFFFF9), rs2=2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF. DIVU 100/7 -> 0x0000000E. REMU -> 0x00000002.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF, wb 1 cycle after acceptance.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Control:
  - MUL with rd=0 -> full 33-cycle busy, wb_reg_write stays 0.
  - flush at cycle 12 of DIV -> IDLE next edge, no write.
  - flush and in_valid together in IDLE -> not accepted.
- With FAST_MUL_EN, MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF, wb 1 cycle after acceptance. Back-to-back accept is possible 2 edges later.
